// File: rtl/mem_buffer_requester_if.sv
// Handshake bundle between the buffer source, the requester and the memory request port.
// The slave modport is the requester side; master is the source/sink side.
interface mem_buffer_requester_if #(
    parameter int unsigned VADDR_BITS      = 48,
    parameter int unsigned SIZE_BITS       = 28,
    parameter int unsigned CHUNK_BYTES     = 4096,
    parameter int unsigned MAX_OUTSTANDING = 8
);
    localparam int unsigned LEN_W = $clog2(CHUNK_BYTES) + 1;
    localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);

    logic                  buf_valid;
    logic                  buf_ready;
    logic [VADDR_BITS-1:0] buf_vaddr;
    logic [SIZE_BITS-1:0]  buf_size;

    logic                  req_valid;
    logic                  req_ready;
    logic [VADDR_BITS-1:0] req_vaddr;
    logic [LEN_W-1:0]      req_len;
    logic                  req_last;

    logic                  cpl_valid;
    logic                  done;
    logic [OUT_W-1:0]      outstanding;
    logic                  cpl_error;

    modport master (
        output buf_valid, buf_vaddr, buf_size, req_ready, cpl_valid,
        input  buf_ready, req_valid, req_vaddr, req_len, req_last, done, outstanding, cpl_error
    );

    modport slave (
        input  buf_valid, buf_vaddr, buf_size, req_ready, cpl_valid,
        output buf_ready, req_valid, req_vaddr, req_len, req_last, done, outstanding, cpl_error
    );
endinterface

// File: rtl/mem_buffer_requester.sv
// Splits one buffer descriptor into chunk-bounded memory requests and tracks their completions.
// Defining MEM_REQUESTER_STATS_EN adds saturating stat_reqs / stat_stalls counters.
module mem_buffer_requester #(
    parameter int unsigned VADDR_BITS      = 48,
    parameter int unsigned SIZE_BITS       = 28,
    parameter int unsigned CHUNK_BYTES     = 4096,
    parameter int unsigned MAX_OUTSTANDING = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_buffer_requester_if.slave bus
`ifdef MEM_REQUESTER_STATS_EN
    ,
    output logic [31:0]           stat_reqs,
    output logic [31:0]           stat_stalls
`endif
);
    localparam int unsigned LEN_W = $clog2(CHUNK_BYTES) + 1;
    localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned CMP_W = (SIZE_BITS > LEN_W) ? SIZE_BITS : LEN_W;

    typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

    state_e                state_q, state_d;
    logic [VADDR_BITS-1:0] addr_q, addr_d;
    logic [SIZE_BITS-1:0]  rem_q, rem_d;
    logic [OUT_W-1:0]      outstanding_q, outstanding_d;
    logic                  cpl_error_q, cpl_error_d;

    logic [LEN_W-1:0]      room;
    logic [CMP_W-1:0]      len_w;
    logic                  req_valid;
    logic                  req_last;
    logic                  req_hs;
    logic                  cpl_ok;
    logic                  buf_ready;
    logic                  done;
    logic                  at_limit;

    // Bytes left before the next chunk boundary, then clipped to what remains of the buffer.
    always_comb begin
        room     = LEN_W'(CHUNK_BYTES) - LEN_W'(addr_q & VADDR_BITS'(CHUNK_BYTES - 1));
        len_w    = (CMP_W'(rem_q) < CMP_W'(room)) ? CMP_W'(rem_q) : CMP_W'(room);
        at_limit = (outstanding_q >= OUT_W'(MAX_OUTSTANDING));
        req_valid = (state_q == StIssue) && !at_limit;
        req_last  = (state_q == StIssue) && (len_w == CMP_W'(rem_q));
        req_hs    = req_valid && bus.req_ready;
        cpl_ok    = bus.cpl_valid && (outstanding_q != '0);
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        buf_ready = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            StIdle: buf_ready = 1'b1;
            StIssue: begin
                if (req_hs) begin
                    addr_d = addr_q + VADDR_BITS'(len_w);
                    rem_d  = rem_q - SIZE_BITS'(len_w);
                    if (req_last) state_d = StDrain;
                end
            end
            StDrain: begin
                // A completion landing this cycle would be spurious; hold done until it clears.
                if (outstanding_q == '0 && !bus.cpl_valid) begin
                    done      = 1'b1;
                    buf_ready = 1'b1;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (buf_ready && bus.buf_valid) begin
            addr_d  = bus.buf_vaddr;
            rem_d   = bus.buf_size;
            state_d = (bus.buf_size == '0) ? StDrain : StIssue;
        end
    end

    always_comb begin
        outstanding_d = outstanding_q;
        case ({req_hs, cpl_ok})
            2'b10:   outstanding_d = outstanding_q + OUT_W'(1);
            2'b01:   outstanding_d = outstanding_q - OUT_W'(1);
            default: outstanding_d = outstanding_q;
        endcase
        cpl_error_d = cpl_error_q | (bus.cpl_valid && (outstanding_q == '0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            addr_q        <= '0;
            rem_q         <= '0;
            outstanding_q <= '0;
            cpl_error_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            rem_q         <= rem_d;
            outstanding_q <= outstanding_d;
            cpl_error_q   <= cpl_error_d;
        end
    end

    assign bus.buf_ready   = buf_ready;
    assign bus.req_valid   = req_valid;
    assign bus.req_vaddr   = addr_q;
    assign bus.req_len     = LEN_W'(len_w);
    assign bus.req_last    = req_last;
    assign bus.done        = done;
    assign bus.outstanding = outstanding_q;
    assign bus.cpl_error   = cpl_error_q;

`ifdef MEM_REQUESTER_STATS_EN
    logic [31:0] stat_reqs_q;
    logic [31:0] stat_stalls_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_reqs_q   <= '0;
            stat_stalls_q <= '0;
        end else begin
            if (req_hs && stat_reqs_q != '1) stat_reqs_q <= stat_reqs_q + 32'd1;
            if ((state_q == StIssue) && at_limit && stat_stalls_q != '1) begin
                stat_stalls_q <= stat_stalls_q + 32'd1;
            end
        end
    end

    assign stat_reqs   = stat_reqs_q;
    assign stat_stalls = stat_stalls_q;
`endif
endmodule

// File: tb/tb_mem_buffer_requester.sv
// Self-checking bench for mem_buffer_requester: vector table, corner sequences and random
// buffers checked against a chunk-splitting reference model.
module tb_mem_buffer_requester;
    localparam int unsigned VB   = 48;
    localparam int unsigned SB   = 28;
    localparam int unsigned CB   = 4096;
    localparam int unsigned MAXO = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_buffer_requester_if #(
        .VADDR_BITS(VB), .SIZE_BITS(SB), .CHUNK_BYTES(CB), .MAX_OUTSTANDING(MAXO)
    ) bus ();

`ifdef MEM_REQUESTER_STATS_EN
    logic [31:0] stat_reqs;
    logic [31:0] stat_stalls;
`endif

    mem_buffer_requester #(
        .VADDR_BITS(VB), .SIZE_BITS(SB), .CHUNK_BYTES(CB), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef MEM_REQUESTER_STATS_EN
        ,
        .stat_reqs(stat_reqs),
        .stat_stalls(stat_stalls)
`endif
    );

    typedef struct {
        logic [VB-1:0] vaddr;
        logic [SB-1:0] size;
        int unsigned   n;
        logic [VB-1:0] a0, a1, a2;
        int unsigned   l0, l1, l2;
    } vec_t;

    vec_t          vecs [6];
    int            total = 0;
    int            bad   = 0;
    logic [VB-1:0] exp_addr [$];
    int unsigned   exp_len  [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.buf_valid = 1'b0;
        bus.req_ready = 1'b0;
        bus.cpl_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Reference: walk the buffer, each piece capped by the distance to the next chunk boundary.
    task automatic model_fill(input logic [VB-1:0] va, input logic [SB-1:0] sz);
        longint unsigned a   = 64'(va);
        longint unsigned rem = 64'(sz);
        longint unsigned len;
        exp_addr.delete();
        exp_len.delete();
        while (rem > 0) begin
            len = CB - (a % CB);
            if (rem < len) len = rem;
            exp_addr.push_back(a[VB-1:0]);
            exp_len.push_back(int'(len));
            a   = (a + len) % (64'd1 << VB);
            rem = rem - len;
        end
    endtask

    task automatic run_buf(input logic [VB-1:0] va, input logic [SB-1:0] sz,
                           input int unsigned rdy_pct, input int unsigned cpl_pct);
        int unsigned   idx  = 0;
        int unsigned   pend = 0;
        bit            got_done = 0;
        bit            held = 0;
        bit            hs;
        logic [VB-1:0] h_addr = '0;
        logic [12:0]   h_len  = '0;
        logic          h_last = 1'b0;
        bus.buf_valid = 1'b1;
        bus.buf_vaddr = va;
        bus.buf_size  = sz;
        bus.req_ready = 1'b0;
        bus.cpl_valid = 1'b0;
        #1 chk("buf_ready_offer", 64'(bus.buf_ready), 64'd1);
        tick();
        bus.buf_valid = 1'b0;
        for (int cyc = 0; cyc < 3000 && !got_done; cyc++) begin
            bus.req_ready = ($urandom_range(99) < rdy_pct);
            bus.cpl_valid = (pend > 0) && ($urandom_range(99) < cpl_pct);
            #1;
            chk("req_valid", 64'(bus.req_valid),
                64'((idx < exp_addr.size()) && (pend < MAXO)));
            chk("outstanding", 64'(bus.outstanding), 64'(pend));
            chk("done", 64'(bus.done),
                64'((idx == exp_addr.size()) && (pend == 0) && !bus.cpl_valid));
            if (held && bus.req_valid) begin
                chk("hold_addr", 64'(bus.req_vaddr), 64'(h_addr));
                chk("hold_len", 64'(bus.req_len), 64'(h_len));
                chk("hold_last", 64'(bus.req_last), 64'(h_last));
            end
            hs = bus.req_valid && bus.req_ready;
            if (hs && idx < exp_addr.size()) begin
                chk("req_addr", 64'(bus.req_vaddr), 64'(exp_addr[idx]));
                chk("req_len", 64'(bus.req_len), 64'(exp_len[idx]));
                chk("req_last", 64'(bus.req_last), 64'(idx == exp_addr.size() - 1));
                idx++;
            end
            held   = bus.req_valid && !bus.req_ready;
            h_addr = bus.req_vaddr;
            h_len  = bus.req_len;
            h_last = bus.req_last;
            if (bus.done) begin
                got_done = 1;
                chk("buf_ready_done", 64'(bus.buf_ready), 64'd1);
            end
            if (hs && !bus.cpl_valid) pend++;
            else if (!hs && bus.cpl_valid) pend--;
            tick();
        end
        bus.req_ready = 1'b0;
        bus.cpl_valid = 1'b0;
        chk("req_count", 64'(idx), 64'(exp_addr.size()));
        chk("done_seen", 64'(got_done), 64'd1);
    endtask

    initial begin
        logic [63:0] r;
        logic [VB-1:0] va;
        logic [SB-1:0] sz;

        vecs[0] = '{vaddr: 48'h1000, size: 28'd8192, n: 2,
                    a0: 48'h1000, l0: 4096, a1: 48'h2000, l1: 4096, a2: '0, l2: 0};
        vecs[1] = '{vaddr: 48'h0F00, size: 28'h300, n: 2,
                    a0: 48'h0F00, l0: 'h100, a1: 48'h1000, l1: 'h200, a2: '0, l2: 0};
        vecs[2] = '{vaddr: 48'h0FFF, size: 28'd4098, n: 3,
                    a0: 48'h0FFF, l0: 1, a1: 48'h1000, l1: 4096, a2: 48'h2000, l2: 1};
        vecs[3] = '{vaddr: 48'hFFFF_FFFF_FF00, size: 28'h200, n: 2,
                    a0: 48'hFFFF_FFFF_FF00, l0: 'h100, a1: 48'h0, l1: 'h100, a2: '0, l2: 0};
        vecs[4] = '{vaddr: 48'h0020, size: 28'd5, n: 1,
                    a0: 48'h0020, l0: 5, a1: '0, l1: 0, a2: '0, l2: 0};
        vecs[5] = '{vaddr: 48'h5000, size: 28'd0, n: 0,
                    a0: '0, l0: 0, a1: '0, l1: 0, a2: '0, l2: 0};

        bus.buf_valid = 1'b0;
        bus.buf_vaddr = '0;
        bus.buf_size  = '0;
        bus.req_ready = 1'b0;
        bus.cpl_valid = 1'b0;
        tick();
        do_reset();
        #1;
        chk("rst_buf_ready", 64'(bus.buf_ready), 64'd1);
        chk("rst_req_valid", 64'(bus.req_valid), 64'd0);
        chk("rst_req_last", 64'(bus.req_last), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_outstanding", 64'(bus.outstanding), 64'd0);
        chk("rst_cpl_error", 64'(bus.cpl_error), 64'd0);
        tick();

        // Table vectors: ready always, completion the cycle after each request.
        for (int v = 0; v < 6; v++) begin
            exp_addr.delete();
            exp_len.delete();
            if (vecs[v].n > 0) begin exp_addr.push_back(vecs[v].a0); exp_len.push_back(vecs[v].l0); end
            if (vecs[v].n > 1) begin exp_addr.push_back(vecs[v].a1); exp_len.push_back(vecs[v].l1); end
            if (vecs[v].n > 2) begin exp_addr.push_back(vecs[v].a2); exp_len.push_back(vecs[v].l2); end
            run_buf(vecs[v].vaddr, vecs[v].size, 100, 100);
        end
        chk("idle_after_table", 64'(bus.buf_ready), 64'd1);

        // Backpressure: outstanding limit of 2 with completions withheld.
        do_reset();
        bus.buf_valid = 1'b1; bus.buf_vaddr = '0; bus.buf_size = 28'd16384;
        tick();
        bus.buf_valid = 1'b0; bus.req_ready = 1'b1;
        #1 chk("bp_req0_addr", 64'(bus.req_vaddr), 64'h0);
        chk("bp_req0_valid", 64'(bus.req_valid), 64'd1);
        tick();
        #1 chk("bp_req1_addr", 64'(bus.req_vaddr), 64'h1000);
        chk("bp_req1_valid", 64'(bus.req_valid), 64'd1);
        tick();
        for (int i = 0; i < 3; i++) begin
            #1 chk("bp_stall_valid", 64'(bus.req_valid), 64'd0);
            chk("bp_stall_out", 64'(bus.outstanding), 64'd2);
            tick();
        end
        bus.cpl_valid = 1'b1;
        #1 chk("bp_cpl_cycle_valid", 64'(bus.req_valid), 64'd0);
        tick();
        bus.cpl_valid = 1'b0; bus.req_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1 chk("bp_req2_valid", 64'(bus.req_valid), 64'd1);
            chk("bp_req2_addr", 64'(bus.req_vaddr), 64'h2000);
            chk("bp_req2_len", 64'(bus.req_len), 64'd4096);
            chk("bp_req2_last", 64'(bus.req_last), 64'd0);
            chk("bp_req2_out", 64'(bus.outstanding), 64'd1);
            tick();
        end
        bus.req_ready = 1'b1;
        tick();
        bus.req_ready = 1'b0;
        #1 chk("bp_full_again_out", 64'(bus.outstanding), 64'd2);
        chk("bp_full_again_valid", 64'(bus.req_valid), 64'd0);
        tick();

        // Simultaneous handshake and completion, then a spurious completion in IDLE.
        do_reset();
        bus.buf_valid = 1'b1; bus.buf_vaddr = '0; bus.buf_size = 28'd8192;
        tick();
        bus.buf_valid = 1'b0; bus.req_ready = 1'b1;
        tick();
        bus.cpl_valid = 1'b1;
        #1 chk("sim_valid", 64'(bus.req_valid), 64'd1);
        chk("sim_out_before", 64'(bus.outstanding), 64'd1);
        tick();
        bus.cpl_valid = 1'b0; bus.req_ready = 1'b0;
        #1 chk("sim_out_after", 64'(bus.outstanding), 64'd1);
        chk("sim_drain_valid", 64'(bus.req_valid), 64'd0);
        tick();
        bus.cpl_valid = 1'b1;
        #1 chk("sim_no_done_yet", 64'(bus.done), 64'd0);
        tick();
        bus.cpl_valid = 1'b0;
        #1 chk("sim_done", 64'(bus.done), 64'd1);
        chk("sim_done_ready", 64'(bus.buf_ready), 64'd1);
        tick();
        bus.cpl_valid = 1'b1;
        #1 chk("spur_err_before", 64'(bus.cpl_error), 64'd0);
        tick();
        bus.cpl_valid = 1'b0;
        #1 chk("spur_err_set", 64'(bus.cpl_error), 64'd1);
        chk("spur_out_zero", 64'(bus.outstanding), 64'd0);
        tick(); tick(); tick();
        #1 chk("spur_err_sticky", 64'(bus.cpl_error), 64'd1);
        do_reset();
        #1 chk("spur_err_cleared", 64'(bus.cpl_error), 64'd0);
        tick();

        // Reset mid-ISSUE after one of three requests.
        bus.buf_valid = 1'b1; bus.buf_vaddr = '0; bus.buf_size = 28'd12288;
        tick();
        bus.buf_valid = 1'b0; bus.req_ready = 1'b1;
        #1 chk("mid_req0_valid", 64'(bus.req_valid), 64'd1);
        tick();
        bus.req_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1 chk("mid_rst_valid", 64'(bus.req_valid), 64'd0);
        chk("mid_rst_out", 64'(bus.outstanding), 64'd0);
        chk("mid_rst_ready", 64'(bus.buf_ready), 64'd1);
        chk("mid_rst_last", 64'(bus.req_last), 64'd0);
        tick();
        model_fill(48'h1000, 28'd8192);
        run_buf(48'h1000, 28'd8192, 100, 100);

        // Random buffers against the reference model.
        for (int t = 0; t < 40; t++) begin
            r  = {$urandom(), $urandom()};
            va = r[VB-1:0];
            if ($urandom_range(3) == 0) va[11:0] = 12'hFFF - 12'($urandom_range(3));
            case ($urandom_range(3))
                0:       sz = SB'($urandom_range(16));
                1:       sz = SB'($urandom_range(5000));
                2:       sz = SB'($urandom_range(20000));
                default: sz = '0;
            endcase
            model_fill(va, sz);
            run_buf(va, sz, $urandom_range(100, 30), $urandom_range(90, 20));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
